// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA/loader requester and dmem.
// The arbiter takes the slave side; requesters and memory take the master side.
interface dmem_arbiter_if;
    // Pipeline MEM stage
    logic        MemReqM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    // DMA / loader requester
    logic        DmaReq;
    logic        DmaWrite;
    logic [31:0] DmaAddr;
    logic [3:0]  DmaLen;
    logic [31:0] DmaWData;
    logic        DmaGnt;
    logic [31:0] DmaRData;
    logic        DmaRValid;
    logic        DmaDone;
    // Data memory port
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWD;
    logic [31:0] MemRD;

    modport slave (
        input  MemReqM, MemWriteM, ALUResultM, WriteDataM,
        input  DmaReq, DmaWrite, DmaAddr, DmaLen, DmaWData,
        input  MemRD,
        output ReadDataM, StallM,
        output DmaGnt, DmaRData, DmaRValid, DmaDone,
        output MemWE, MemAddr, MemWD
    );

    modport master (
        output MemReqM, MemWriteM, ALUResultM, WriteDataM,
        output DmaReq, DmaWrite, DmaAddr, DmaLen, DmaWData,
        output MemRD,
        input  ReadDataM, StallM,
        input  DmaGnt, DmaRData, DmaRValid, DmaDone,
        input  MemWE, MemAddr, MemWD
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: pipeline MEM stage has priority, DMA gets bounded
// auto-incrementing bursts, and a starvation counter forces the DMA in
// after repeated losses (the MEM stage is then held with StallM).
module dmem_arbiter #(
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t      state_q, state_d;
    logic [3:0]  beats_q, beats_d;
    logic [31:0] burstAddr_q, burstAddr_d;
    logic        burstWrite_q, burstWrite_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0] dmaRData_q, dmaRData_d;
    logic        dmaRValid_q, dmaRValid_d;

    logic [3:0]  lenEff;
    logic        dmaWin;
    logic        pipeWin;
    logic        beatGnt;
    logic        beatWrite;

    // Effective burst length: zero means one beat, long requests are clipped.
    always_comb begin
        lenEff = bus.DmaLen;
        if (bus.DmaLen == 4'd0)
            lenEff = 4'd1;
        else if (bus.DmaLen > 4'(MAX_BURST))
            lenEff = 4'(MAX_BURST);
    end

    // Grant decision in IDLE; starve never exceeds the limit so == is the forced case.
    always_comb begin
        dmaWin  = (state_q == IDLE) && bus.DmaReq &&
                  (!bus.MemReqM || (starve_q == SW'(STARVE_LIMIT)));
        pipeWin = (state_q == IDLE) && bus.MemReqM && !dmaWin;
    end

    // State and datapath registers, cleared asynchronously so a reset aborts any burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            beats_q      <= '0;
            burstAddr_q  <= '0;
            burstWrite_q <= 1'b0;
            starve_q     <= '0;
            dmaRData_q   <= '0;
            dmaRValid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_q      <= beats_d;
            burstAddr_q  <= burstAddr_d;
            burstWrite_q <= burstWrite_d;
            starve_q     <= starve_d;
            dmaRData_q   <= dmaRData_d;
            dmaRValid_q  <= dmaRValid_d;
        end
    end

    // Next-state logic: burst bookkeeping, starvation tracking and DMA read capture.
    always_comb begin
        state_d      = state_q;
        beats_d      = beats_q;
        burstAddr_d  = burstAddr_q;
        burstWrite_d = burstWrite_q;
        starve_d     = starve_q;
        dmaRData_d   = dmaRData_q;
        dmaRValid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (dmaWin && (lenEff != 4'd1)) begin
                    state_d      = BURST;
                    beats_d      = lenEff - 4'd1;
                    burstAddr_d  = bus.DmaAddr + 32'd4;
                    burstWrite_d = bus.DmaWrite;
                end
            end
            BURST: begin
                beats_d     = beats_q - 4'd1;
                burstAddr_d = burstAddr_q + 32'd4;
                if (beats_q == 4'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!bus.DmaReq || beatGnt)
            starve_d = '0;
        else if (pipeWin && (starve_q != SW'(STARVE_LIMIT)))
            starve_d = starve_q + SW'(1);

        if (beatGnt && !beatWrite) begin
            dmaRData_d  = bus.MemRD;
            dmaRValid_d = 1'b1;
        end
    end

    // A DMA beat happens on every BURST cycle and on an IDLE DMA win.
    always_comb begin
        beatGnt   = dmaWin || (state_q == BURST);
        beatWrite = (state_q == BURST) ? burstWrite_q : bus.DmaWrite;
    end

    // Output steering; everything is forced inactive while reset is held low.
    always_comb begin
        bus.ReadDataM = bus.MemRD;
        bus.DmaRData  = dmaRData_q;
        bus.DmaRValid = dmaRValid_q;
        bus.MemWE     = 1'b0;
        bus.MemAddr   = bus.ALUResultM;
        bus.MemWD     = bus.WriteDataM;
        bus.DmaGnt    = 1'b0;
        bus.DmaDone   = 1'b0;
        bus.StallM    = 1'b0;

        if (!reset) begin
            bus.MemAddr = '0;
            bus.MemWD   = '0;
        end else if (state_q == BURST) begin
            bus.MemAddr = burstAddr_q;
            bus.MemWE   = burstWrite_q;
            bus.MemWD   = bus.DmaWData;
            bus.DmaGnt  = 1'b1;
            bus.StallM  = bus.MemReqM;
            bus.DmaDone = (beats_q == 4'd1);
        end else if (dmaWin) begin
            bus.MemAddr = bus.DmaAddr;
            bus.MemWE   = bus.DmaWrite;
            bus.MemWD   = bus.DmaWData;
            bus.DmaGnt  = 1'b1;
            bus.StallM  = bus.MemReqM;
            bus.DmaDone = (lenEff == 4'd1);
        end else if (pipeWin) begin
            bus.MemWE   = bus.MemWriteM;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed dmem model.
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    logic [31:0] mem [0:255];

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MAX_BURST(8), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock generation, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge.
    assign bus.MemRD = mem[bus.MemAddr[9:2]];
    always @(posedge clk) begin
        if (bus.MemWE)
            mem[bus.MemAddr[9:2]] <= bus.MemWD;
    end

    // Move to the drive point just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idleInputs();
        bus.MemReqM    = 1'b0;
        bus.MemWriteM  = 1'b0;
        bus.ALUResultM = 32'h0;
        bus.WriteDataM = 32'h0;
        bus.DmaReq     = 1'b0;
        bus.DmaWrite   = 1'b0;
        bus.DmaAddr    = 32'h0;
        bus.DmaLen     = 4'd0;
        bus.DmaWData   = 32'h0;
    endtask

    // Reset forces combinational outputs inactive even with both requesters active.
    task automatic test_reset();
        bus.MemReqM    = 1'b1;
        bus.MemWriteM  = 1'b1;
        bus.ALUResultM = 32'h44;
        bus.WriteDataM = 32'h1234;
        bus.DmaReq     = 1'b1;
        bus.DmaWrite   = 1'b1;
        bus.DmaAddr    = 32'h100;
        bus.DmaLen     = 4'd2;
        bus.DmaWData   = 32'h55;
        reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        compared++; if (bus.MemWE !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we: got %0h want 0", bus.MemWE); end
        compared++; if (bus.DmaGnt !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_gnt: got %0h want 0", bus.DmaGnt); end
        compared++; if (bus.DmaDone !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %0h want 0", bus.DmaDone); end
        compared++; if (bus.StallM !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %0h want 0", bus.StallM); end
        compared++; if (bus.MemAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_addr: got %08h want 0", bus.MemAddr); end
        compared++; if (bus.DmaRValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rvalid: got %0h want 0", bus.DmaRValid); end
        compared++; if (bus.DmaRData !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %08h want 0", bus.DmaRData); end
        nextCycle();
        idleInputs();
        reset = 1'b1;
        nextCycle();
    endtask

    // Pipeline-only store then load, then a no-access cycle.
    task automatic test_pipeline();
        bus.MemReqM = 1'b1; bus.MemWriteM = 1'b1;
        bus.ALUResultM = 32'h40; bus.WriteDataM = 32'hDEADBEEF;
        @(negedge clk);
        compared++; if (bus.MemWE !== 1'b1) begin mismatched++; $display("[TB] FAIL pipe_store_we: got %0h want 1", bus.MemWE); end
        compared++; if (bus.MemAddr !== 32'h40) begin mismatched++; $display("[TB] FAIL pipe_store_addr: got %08h want 40", bus.MemAddr); end
        compared++; if (bus.MemWD !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL pipe_store_wd: got %08h want deadbeef", bus.MemWD); end
        compared++; if (bus.StallM !== 1'b0) begin mismatched++; $display("[TB] FAIL pipe_store_stall: got %0h want 0", bus.StallM); end
        nextCycle();
        bus.MemWriteM = 1'b0;
        @(negedge clk);
        compared++; if (bus.MemWE !== 1'b0) begin mismatched++; $display("[TB] FAIL pipe_load_we: got %0h want 0", bus.MemWE); end
        compared++; if (bus.ReadDataM !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL pipe_load_data: got %08h want deadbeef", bus.ReadDataM); end
        compared++; if (bus.StallM !== 1'b0) begin mismatched++; $display("[TB] FAIL pipe_load_stall: got %0h want 0", bus.StallM); end
        nextCycle();
        bus.MemReqM = 1'b0; bus.ALUResultM = 32'h80;
        @(negedge clk);
        compared++; if (bus.MemWE !== 1'b0) begin mismatched++; $display("[TB] FAIL noacc_we: got %0h want 0", bus.MemWE); end
        compared++; if (bus.MemAddr !== 32'h80) begin mismatched++; $display("[TB] FAIL noacc_addr: got %08h want 80", bus.MemAddr); end
        nextCycle();
    endtask

    // Three-beat DMA write burst at 0x100 with the pipeline idle.
    task automatic test_dma_write();
        bus.DmaReq = 1'b1; bus.DmaWrite = 1'b1; bus.DmaAddr = 32'h100;
        bus.DmaLen = 4'd3; bus.DmaWData = 32'hA0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++; if (bus.DmaGnt !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_gnt%0d: got %0h want 1", i, bus.DmaGnt); end
            compared++; if (bus.MemAddr !== 32'h100 + 32'(4 * i)) begin mismatched++; $display("[TB] FAIL wr_addr%0d: got %08h want %08h", i, bus.MemAddr, 32'h100 + 32'(4 * i)); end
            compared++; if (bus.MemWE !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_we%0d: got %0h want 1", i, bus.MemWE); end
            compared++; if (bus.DmaDone !== (i == 2)) begin mismatched++; $display("[TB] FAIL wr_done%0d: got %0h want %0h", i, bus.DmaDone, (i == 2)); end
            nextCycle();
            bus.DmaWData = 32'hA1 + 32'(i);
            if (i == 2) bus.DmaReq = 1'b0;
        end
        @(negedge clk);
        compared++; if (bus.DmaGnt !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_idle_gnt: got %0h want 0", bus.DmaGnt); end
        compared++; if (mem[8'h41] !== 32'hA1) begin mismatched++; $display("[TB] FAIL wr_mem104: got %08h want a1", mem[8'h41]); end
        compared++; if (mem[8'h42] !== 32'hA2) begin mismatched++; $display("[TB] FAIL wr_mem108: got %08h want a2", mem[8'h42]); end
        nextCycle();
    endtask

    // DmaLen=0 read gives one beat and registered data a cycle later.
    task automatic test_dma_read_len0();
        bus.DmaReq = 1'b1; bus.DmaWrite = 1'b0; bus.DmaAddr = 32'h104; bus.DmaLen = 4'd0;
        @(negedge clk);
        compared++; if (bus.DmaGnt !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_gnt: got %0h want 1", bus.DmaGnt); end
        compared++; if (bus.DmaDone !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_done: got %0h want 1", bus.DmaDone); end
        compared++; if (bus.MemWE !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_we: got %0h want 0", bus.MemWE); end
        nextCycle();
        bus.DmaReq = 1'b0;
        @(negedge clk);
        compared++; if (bus.DmaGnt !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_gnt_after: got %0h want 0", bus.DmaGnt); end
        compared++; if (bus.DmaRValid !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_rvalid: got %0h want 1", bus.DmaRValid); end
        compared++; if (bus.DmaRData !== 32'hA1) begin mismatched++; $display("[TB] FAIL rd_rdata: got %08h want a1", bus.DmaRData); end
        nextCycle();
        @(negedge clk);
        compared++; if (bus.DmaRValid !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_rvalid_drop: got %0h want 0", bus.DmaRValid); end
        nextCycle();
    endtask

    // Four pipeline wins, then a forced 2-beat DMA read burst stalling the MEM stage.
    task automatic test_starvation();
        bus.MemReqM = 1'b1; bus.MemWriteM = 1'b0; bus.ALUResultM = 32'h40;
        bus.DmaReq = 1'b1; bus.DmaWrite = 1'b0; bus.DmaAddr = 32'h100; bus.DmaLen = 4'd2;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            compared++; if (bus.DmaGnt !== (c == 4 || c == 5)) begin mismatched++; $display("[TB] FAIL starve_gnt%0d: got %0h want %0h", c, bus.DmaGnt, (c == 4 || c == 5)); end
            compared++; if (bus.StallM !== (c == 4 || c == 5)) begin mismatched++; $display("[TB] FAIL starve_stall%0d: got %0h want %0h", c, bus.StallM, (c == 4 || c == 5)); end
            if (c == 5) begin
                compared++; if (bus.MemAddr !== 32'h104) begin mismatched++; $display("[TB] FAIL starve_addr: got %08h want 104", bus.MemAddr); end
                compared++; if (bus.DmaDone !== 1'b1) begin mismatched++; $display("[TB] FAIL starve_done: got %0h want 1", bus.DmaDone); end
            end
            if (c == 6) begin
                compared++; if (bus.MemAddr !== 32'h40) begin mismatched++; $display("[TB] FAIL starve_resume_addr: got %08h want 40", bus.MemAddr); end
                compared++; if (bus.DmaRData !== 32'hA1) begin mismatched++; $display("[TB] FAIL starve_rdata: got %08h want a1", bus.DmaRData); end
            end
            nextCycle();
            if (c == 5) bus.DmaReq = 1'b0;
        end
        idleInputs();
        nextCycle();
    endtask

    // DmaLen=15 is clipped to 8 beats; stall run never exceeds 8.
    task automatic test_max_burst();
        int beats, run, maxRun, dones;
        logic [31:0] wd;
        beats = 0; run = 0; maxRun = 0; dones = 0; wd = 32'h500;
        bus.MemReqM = 1'b1; bus.ALUResultM = 32'h40;
        bus.DmaReq = 1'b1; bus.DmaWrite = 1'b1; bus.DmaAddr = 32'h200; bus.DmaLen = 4'd15;
        bus.DmaWData = wd;
        for (int c = 0; c < 24; c++) begin
            logic sawGnt, sawDone;
            @(negedge clk);
            sawGnt  = bus.DmaGnt;
            sawDone = bus.DmaDone;
            if (bus.StallM) run++; else run = 0;
            if (run > maxRun) maxRun = run;
            if (sawGnt) begin
                compared++; if (bus.MemAddr !== 32'h200 + 32'(4 * beats)) begin mismatched++; $display("[TB] FAIL max_addr%0d: got %08h want %08h", beats, bus.MemAddr, 32'h200 + 32'(4 * beats)); end
                beats++;
            end
            if (sawDone) dones++;
            nextCycle();
            if (sawGnt) begin wd = wd + 32'd1; bus.DmaWData = wd; end
            if (sawDone) bus.DmaReq = 1'b0;
        end
        compared++; if (beats !== 8) begin mismatched++; $display("[TB] FAIL max_beats: got %0d want 8", beats); end
        compared++; if (dones !== 1) begin mismatched++; $display("[TB] FAIL max_dones: got %0d want 1", dones); end
        compared++; if (maxRun !== 8) begin mismatched++; $display("[TB] FAIL max_stall_run: got %0d want 8", maxRun); end
        compared++; if (mem[8'h87] !== 32'h507) begin mismatched++; $display("[TB] FAIL max_last_word: got %08h want 507", mem[8'h87]); end
        compared++; if (mem[8'h88] !== 32'h0) begin mismatched++; $display("[TB] FAIL max_past_end: got %08h want 0", mem[8'h88]); end
        idleInputs();
        nextCycle();
    endtask

    // Reset on the 2nd beat aborts the burst; after release it restarts at DmaAddr.
    task automatic test_reset_mid_burst();
        int beats, dones;
        beats = 0; dones = 0;
        bus.DmaReq = 1'b1; bus.DmaWrite = 1'b1; bus.DmaAddr = 32'h300; bus.DmaLen = 4'd4;
        bus.DmaWData = 32'h600;
        @(negedge clk);
        compared++; if (bus.DmaGnt !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_beat0_gnt: got %0h want 1", bus.DmaGnt); end
        nextCycle();
        bus.DmaWData = 32'h601;
        reset = 1'b0;
        @(negedge clk);
        compared++; if (bus.DmaGnt !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_gnt: got %0h want 0", bus.DmaGnt); end
        compared++; if (bus.MemWE !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_we: got %0h want 0", bus.MemWE); end
        compared++; if (bus.DmaDone !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_done: got %0h want 0", bus.DmaDone); end
        compared++; if (bus.MemAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_mid_addr: got %08h want 0", bus.MemAddr); end
        nextCycle();
        reset = 1'b1;
        bus.DmaWData = 32'h700;
        for (int c = 0; c < 6; c++) begin
            logic sawGnt, sawDone;
            @(negedge clk);
            sawGnt  = bus.DmaGnt;
            sawDone = bus.DmaDone;
            if (sawGnt) begin
                compared++; if (bus.MemAddr !== 32'h300 + 32'(4 * beats)) begin mismatched++; $display("[TB] FAIL rst_restart_addr%0d: got %08h want %08h", beats, bus.MemAddr, 32'h300 + 32'(4 * beats)); end
                beats++;
            end
            if (sawDone) dones++;
            nextCycle();
            if (sawGnt) bus.DmaWData = bus.DmaWData + 32'd1;
            if (sawDone) bus.DmaReq = 1'b0;
        end
        compared++; if (beats !== 4) begin mismatched++; $display("[TB] FAIL rst_restart_beats: got %0d want 4", beats); end
        compared++; if (dones !== 1) begin mismatched++; $display("[TB] FAIL rst_restart_dones: got %0d want 1", dones); end
        compared++; if (mem[8'hC1] !== 32'h701) begin mismatched++; $display("[TB] FAIL rst_restart_mem: got %08h want 701", mem[8'hC1]); end
        idleInputs();
        nextCycle();
    endtask

    // Test sequence.
    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        idleInputs();
        reset = 1'b1;
        test_reset();
        test_pipeline();
        test_dma_write();
        test_dma_read_len0();
        test_starvation();
        test_max_burst();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
